fifo_seg_view: RTL and testbench

Parametrised FIFO-to-display subsystem: buffers WIDTH-bit words from a producer into a DEPTH-entry FIFO, pops them at a programmable pace, and shows either the popped value or the FIFO occupancy in hex on an N_DIG-digit multiplexed 7-segment display. It replaces the fixed 8-bit/16-deep FIFO, reader and 4-digit driver trio with one configurable block. It adds overflow tracking and an occupancy view mode.

---
 rtl/fifo_seg_pkg.sv | 21 ++
 rtl/fifo_seg_view_seg_scan.sv | 52 +++++
 rtl/fifo_seg_view.sv | 136 +++++++++++++
 tb/tb_fifo_seg_view.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_seg_pkg.sv
// Shared types and glyph table for the FIFO-to-display block.
package fifo_seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FETCH = 2'd2,
        LOAD  = 2'd3
    } rd_state_t;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/fifo_seg_view_seg_scan.sv
// Multiplexed hex display driver: one digit lit per refresh period, ss/dig registered.
module seg_scan
    import fifo_seg_pkg::*;
#(
    parameter int N_DIG   = 4,
    parameter int REFRESH = 50_000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [4*N_DIG-1:0] value,
    output logic [6:0]         ss,
    output logic [N_DIG-1:0]   dig
);

    localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    logic [RW-1:0]    rcnt;
    logic [IW-1:0]    idx;
    logic [3:0]       nib;
    logic [N_DIG-1:0] dig_nxt;

    always_comb begin
        nib     = '0;
        dig_nxt = '1;
        for (int k = 0; k < N_DIG; k++) begin
            if (idx == IW'(k)) begin
                nib        = value[4*k +: 4];
                dig_nxt[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rcnt <= '0;
            idx  <= '0;
            ss   <= hex_glyph(4'h0);
            dig  <= ~(N_DIG'(1));
        end else begin
            if (rcnt == RW'(REFRESH - 1)) begin
                rcnt <= '0;
                idx  <= (idx == IW'(N_DIG - 1)) ? '0 : idx + IW'(1);
            end else begin
                rcnt <= rcnt + RW'(1);
            end
            ss  <= hex_glyph(nib);
            dig <= dig_nxt;
        end
    end

endmodule

// File: rtl/fifo_seg_view.sv
// FIFO with a paced reader feeding a hex display of either the popped word or the occupancy.
module fifo_seg_view
    import fifo_seg_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int N_DIG   = 4,
    parameter int HOLD    = 50_000_000,
    parameter int REFRESH = 50_000
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         wrreq,
    input  logic [WIDTH-1:0]             data,
    input  logic                         ENrd,
    input  logic                         mode,
    input  logic                         ovf_clr,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   usedw,
    output logic                         ovf,
    output logic                         shown,
    output logic [6:0]                   ss,
    output logic [N_DIG-1:0]             dig,
    output rd_state_t                    dbg_state,
    output logic [WIDTH-1:0]             dbg_word
);

    localparam int AW = $clog2(DEPTH);
    localparam int UW = $clog2(DEPTH + 1);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int VW = 4 * N_DIG;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [UW-1:0]    cnt_q;
    logic [WIDTH-1:0] q, disp;
    logic [HW-1:0]    hold_cnt;
    rd_state_t        state;
    logic             push, pop, drop;
    logic [VW-1:0]    view;

    // Producer handshake: wrreq is a request, full is the only backpressure; a
    // request seen while full with no same-cycle pop is dropped and flagged in ovf.
    assign pop   = (state == FETCH);
    assign full  = (cnt_q == UW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign push  = wrreq && (!full || pop);
    assign drop  = wrreq && full && !pop;

    always_ff @(posedge CLK) begin
        if (push) mem[wptr] <= data;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
            q     <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) begin
                rptr <= rptr + AW'(1);
                q    <= mem[rptr];
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + UW'(1);
                2'b01:   cnt_q <= cnt_q - UW'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    // COUNT parks at HOLD-1 while empty so a late word is fetched immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            hold_cnt <= '0;
            disp     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ENrd) begin
                        state    <= COUNT;
                        hold_cnt <= '0;
                    end
                end
                COUNT: begin
                    if (!ENrd) begin
                        state <= IDLE;
                    end else if (hold_cnt == HW'(HOLD - 1)) begin
                        if (!empty) state <= FETCH;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    disp     <= q;
                    state    <= COUNT;
                    hold_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign usedw     = cnt_q;
    assign shown     = (state == LOAD);
    assign dbg_state = state;
    assign dbg_word  = disp;

    always_comb begin
        view = '0;
        if (mode) view[UW-1:0]    = cnt_q;
        else      view[WIDTH-1:0] = disp;
    end

    seg_scan #(
        .N_DIG  (N_DIG),
        .REFRESH(REFRESH)
    ) u_scan (
        .CLK  (CLK),
        .RST  (RST),
        .value(view),
        .ss   (ss),
        .dig  (dig)
    );

    pop_not_empty: assert property (@(posedge CLK) disable iff (!RST) !(pop && empty));

endmodule

// File: tb/tb_fifo_seg_view.sv
// Directed bench for fifo_seg_view; a monitor checks each displayed word against an expected queue.
module tb_fifo_seg_view;

    localparam int WIDTH = 8, DEPTH = 4, N_DIG = 4, HOLD = 4, REFRESH = 2;
    localparam logic [1:0] S_IDLE = 2'd0, S_COUNT = 2'd1, S_FETCH = 2'd2, S_LOAD = 2'd3;

    logic             CLK, RST, wrreq, ENrd, mode, ovf_clr;
    logic [WIDTH-1:0] data;
    logic             full, empty, ovf, shown;
    logic [2:0]       usedw;
    logic [6:0]       ss;
    logic [3:0]       dig;
    logic [1:0]       st;
    logic [WIDTH-1:0] dbg_word;

    logic [WIDTH-1:0] exp_q[$];
    int n_pass = 0, n_total = 0;
    int cyc = 0, last_cyc = 0;
    bit pend = 0, have_last = 0, spacing_en = 0;

    fifo_seg_view #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .N_DIG(N_DIG), .HOLD(HOLD), .REFRESH(REFRESH)
    ) dut (
        .CLK(CLK), .RST(RST), .wrreq(wrreq), .data(data), .ENrd(ENrd), .mode(mode),
        .ovf_clr(ovf_clr), .full(full), .empty(empty), .usedw(usedw), .ovf(ovf),
        .shown(shown), .ss(ss), .dig(dig), .dbg_state(st), .dbg_word(dbg_word)
    );

    // clock and watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: got timeout/unexpected event, expected none", name);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // monitor: a word is in the display register one edge after shown
    always @(negedge CLK) begin
        if (!RST) begin
            pend      = 0;
            have_last = 0;
        end else begin
            if (pend) begin
                if (exp_q.size() == 0) fail("shown_unexpected");
                else check("disp_word", dbg_word, exp_q.pop_front());
                pend = 0;
            end
            if (shown) begin
                pend = 1;
                if (spacing_en && have_last) check("shown_spacing", cyc - last_cyc, 6);
                last_cyc  = cyc;
                have_last = spacing_en;
            end
        end
    end

    logic [WIDTH-1:0] fill [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [3:0] scan_dig [8] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};
    logic [6:0] scan_ss  [8] = '{7'h0E, 7'h0E, 7'h30, 7'h30, 7'h40, 7'h40, 7'h40, 7'h40};

    task automatic wait_digit0();
        logic [3:0] prev;
        int k;
        prev = dig;
        k = 0;
        @(negedge CLK);
        while (!(dig == 4'b1110 && prev != 4'b1110) && k < 20) begin
            prev = dig;
            @(negedge CLK);
            k++;
        end
        if (k >= 20) fail("scan_align_timeout");
    endtask

    initial begin
        int lat, k;
        RST = 1'b0; wrreq = 1'b0; data = '0; ENrd = 1'b0; mode = 1'b0; ovf_clr = 1'b0;

        // reset with random inputs
        repeat (3) begin
            step();
            wrreq   = 1'($urandom_range(0, 1));
            data    = 8'($urandom_range(0, 255));
            ENrd    = 1'($urandom_range(0, 1));
            mode    = 1'($urandom_range(0, 1));
            ovf_clr = 1'($urandom_range(0, 1));
        end
        @(negedge CLK);
        check("rst_usedw", usedw, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", ovf, 0);
        check("rst_shown", shown, 0);
        check("rst_dig", dig, 4'b1110);
        check("rst_ss", ss, 7'h40);
        check("rst_state", st, S_IDLE);
        step();
        wrreq = 0; data = '0; ENrd = 0; mode = 0; ovf_clr = 0;
        RST = 1'b1;
        step();

        // fill past full
        for (int i = 0; i < 5; i++) begin
            wrreq = 1'b1;
            data  = fill[i];
            if (i < 4) exp_q.push_back(fill[i]);
            step();
        end
        @(negedge CLK);
        check("fill_full", full, 1);
        check("fill_usedw", usedw, 4);
        check("fill_ovf", ovf, 1);
        data = 8'h66; ovf_clr = 1'b1;
        step();
        wrreq = 1'b0; ovf_clr = 1'b0;
        @(negedge CLK);
        check("ovf_set_wins", ovf, 1);
        check("drop_usedw", usedw, 4);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        @(negedge CLK);
        check("ovf_cleared", ovf, 0);

        // paced drain, with a push on the first FETCH while full
        spacing_en = 1;
        step();
        ENrd = 1'b1;
        lat = 0;
        do begin
            step();
            lat++;
        end while (st != S_FETCH && lat < 20);
        check("first_fetch_lat", lat, HOLD + 1);
        wrreq = 1'b1; data = 8'hA5;
        exp_q.push_back(8'hA5);
        step();
        wrreq = 1'b0;
        @(negedge CLK);
        check("pushpop_usedw", usedw, 4);
        check("pushpop_full", full, 1);
        check("pushpop_ovf", ovf, 0);
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 100) fail("drain_timeout");
        repeat (8) @(negedge CLK);
        check("drain_empty", empty, 1);
        check("drain_usedw", usedw, 0);
        check("drain_saturate", st, S_COUNT);
        check("drain_no_shown", shown, 0);
        spacing_en = 0;

        // push while COUNT is saturated; ENrd drops during FETCH
        step();
        wrreq = 1'b1; data = 8'h3F;
        exp_q.push_back(8'h3F);
        step();
        wrreq = 1'b0;
        @(negedge CLK);
        check("late_empty", empty, 0);
        check("late_count", st, S_COUNT);
        @(negedge CLK);
        check("late_fetch", st, S_FETCH);
        ENrd = 1'b0;
        repeat (6) @(negedge CLK);
        check("late_idle", st, S_IDLE);
        check("late_word_shown", exp_q.size(), 0);

        // scan of 0x3F in mode 0
        wait_digit0();
        for (int i = 0; i < 8; i++) begin
            check("scan_dig", dig, scan_dig[i]);
            check("scan_ss", ss, scan_ss[i]);
            @(negedge CLK);
        end

        // occupancy view
        step();
        for (int i = 0; i < 3; i++) begin
            wrreq = 1'b1;
            data  = 8'(i + 1);
            step();
        end
        wrreq = 1'b0;
        mode  = 1'b1;
        repeat (3) @(negedge CLK);
        check("mode1_usedw", usedw, 3);
        wait_digit0();
        check("mode1_ss_d0", ss, 7'h30);
        @(negedge CLK);
        @(negedge CLK);
        check("mode1_dig_d1", dig, 4'b1101);
        check("mode1_ss_d1", ss, 7'h40);

        // async reset in the middle of LOAD
        mode = 1'b0;
        step();
        ENrd = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while (st != S_LOAD && k < 30);
        if (k >= 30) fail("load_wait_timeout");
        #1 RST = 1'b0;
        #1;
        check("arst_state", st, S_IDLE);
        check("arst_shown", shown, 0);
        check("arst_usedw", usedw, 0);
        check("arst_empty", empty, 1);
        check("arst_dig", dig, 4'b1110);
        check("arst_ss", ss, 7'h40);
        check("arst_word", dbg_word, 0);
        step();
        RST = 1'b1;
        wrreq = 1'b1; data = 8'h5A;
        exp_q.push_back(8'h5A);
        step();
        wrreq = 1'b0;
        lat = 1;
        while (!shown && lat < 30) begin
            step();
            lat++;
        end
        check("arst_reload_lat", lat, HOLD + 2);
        ENrd = 1'b0;
        repeat (4) @(negedge CLK);
        check("all_words_shown", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
